// File: rtl/scie_issuer.sv
// SCIE coefficient/sample issuer: sequences LOAD, PUSH, GAP, READ, CAPTURE, HOLD over a SCIE issue bus.
// Optional result counter enabled by defining SCIE_ISSUER_PERF_EN.
module scie_issuer #(
  parameter int NTAPS = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               coef_valid,
  output logic               coef_ready,
  input  logic signed [15:0] coef_real,
  input  logic signed [15:0] coef_imag,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] in_real,
  input  logic signed [15:0] in_imag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_real,
  output logic signed [15:0] out_imag,
  output logic               scie_valid,
  output logic        [31:0] scie_insn,
  output logic signed [15:0] scie_rs1_real,
  output logic signed [15:0] scie_rs1_imag,
  output logic        [31:0] scie_rs2,
  input  logic signed [15:0] scie_rd_real,
  input  logic signed [15:0] scie_rd_imag
`ifdef SCIE_ISSUER_PERF_EN
  ,
  output logic        [15:0] result_count
`endif
);

  localparam logic [31:0] INSN_LOAD = 32'h0000_000B;
  localparam logic [31:0] INSN_PUSH = 32'h0000_002B;
  localparam logic [31:0] INSN_READ = 32'h0000_005B;
  localparam int          IDX_W     = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NTAPS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PUSH,
    S_GAP,
    S_READ,
    S_CAPTURE,
    S_HOLD
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [IDX_W-1:0]  r_tap_idx;
  logic              r_loaded;
  logic              w_coef_hs;
  logic              w_in_hs;
  logic              w_out_hs;

  logic              r_scie_valid;
  logic [31:0]       r_scie_insn;
  logic signed [15:0] r_rs1_real;
  logic signed [15:0] r_rs1_imag;
  logic [31:0]       r_scie_rs2;
  logic              r_out_valid;
  logic signed [15:0] r_out_real;
  logic signed [15:0] r_out_imag;

  // A coefficient offered in IDLE always wins, so the sample side is masked by coef_valid.
  assign coef_ready = (r_state == S_IDLE);
  assign in_ready   = (r_state == S_IDLE) && r_loaded && !coef_valid;
  assign w_coef_hs  = coef_valid && coef_ready;
  assign w_in_hs    = in_valid && in_ready;
  assign w_out_hs   = (r_state == S_HOLD) && out_ready;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_coef_hs)    w_next = S_LOAD;
        else if (w_in_hs) w_next = S_PUSH;
      end
      S_LOAD:    w_next = S_IDLE;
      S_PUSH:    w_next = S_GAP;
      S_GAP:     w_next = S_READ;
      S_READ:    w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_HOLD;
      S_HOLD:    if (w_out_hs) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_tap_idx <= '0;
      r_loaded  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_coef_hs) begin
        if (r_tap_idx == IDX_LAST) begin
          r_tap_idx <= '0;
          r_loaded  <= 1'b1;
        end else begin
          r_tap_idx <= r_tap_idx + 1'b1;
        end
      end
    end
  end

  // Issue bus is loaded on the edge that enters an issuing state and holds otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_scie_valid <= 1'b0;
      r_scie_insn  <= '0;
      r_rs1_real   <= '0;
      r_rs1_imag   <= '0;
      r_scie_rs2   <= '0;
    end else begin
      r_scie_valid <= 1'b0;
      unique case (w_next)
        S_LOAD: if (r_state == S_IDLE) begin
          r_scie_valid <= 1'b1;
          r_scie_insn  <= INSN_LOAD;
          r_rs1_real   <= coef_real;
          r_rs1_imag   <= coef_imag;
          r_scie_rs2   <= 32'(r_tap_idx);
        end
        S_PUSH: if (r_state == S_IDLE) begin
          r_scie_valid <= 1'b1;
          r_scie_insn  <= INSN_PUSH;
          r_rs1_real   <= in_real;
          r_rs1_imag   <= in_imag;
          r_scie_rs2   <= '0;
        end
        S_READ: if (r_state == S_GAP) begin
          r_scie_valid <= 1'b1;
          r_scie_insn  <= INSN_READ;
          r_rs1_real   <= '0;
          r_rs1_imag   <= '0;
          r_scie_rs2   <= '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_real  <= '0;
      r_out_imag  <= '0;
    end else begin
      r_out_valid <= (w_next == S_HOLD);
      if (r_state == S_CAPTURE) begin
        r_out_real <= scie_rd_real;
        r_out_imag <= scie_rd_imag;
      end
    end
  end

  assign scie_valid    = r_scie_valid;
  assign scie_insn     = r_scie_insn;
  assign scie_rs1_real = r_rs1_real;
  assign scie_rs1_imag = r_rs1_imag;
  assign scie_rs2      = r_scie_rs2;
  assign out_valid     = r_out_valid;
  assign out_real      = r_out_real;
  assign out_imag      = r_out_imag;

`ifdef SCIE_ISSUER_PERF_EN
  logic [15:0] r_result_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_result_count <= '0;
    end else if (w_out_hs && (r_result_count != 16'hFFFF)) begin
      r_result_count <= r_result_count + 16'd1;
    end
  end

  assign result_count = r_result_count;
`endif

endmodule

// File: doc/scie_issuer.md
SCIE_ISSUER -- requirements
Module: scie_issuer

Interface
REQ-001 The block SHALL have parameter NTAPS, default 5: number of complex coefficients loaded per tap set (2..16).
REQ-002 The block SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 The block SHALL have ports coef_valid in 1, coef_ready out 1, coef_real in 16 signed, coef_imag in 16 signed: coefficient stream.
REQ-005 The block SHALL have ports in_valid in 1, in_ready out 1, in_real in 16 signed, in_imag in 16 signed: sample stream.
REQ-006 The block SHALL have ports out_valid out 1, out_ready in 1, out_real out 16 signed, out_imag out 16 signed: result stream.
REQ-007 The block SHALL have ports scie_valid out 1, scie_insn out 32, scie_rs1_real out 16 signed, scie_rs1_imag out 16 signed, scie_rs2 out 32: SCIE issue bus; all registered.
REQ-008 The block SHALL have ports scie_rd_real in 16 signed, scie_rd_imag in 16 signed: SCIE result bus.

Function
REQ-009 Encodings SHALL be: LOAD = 32'h0000000B, PUSH = 32'h0000002B, READ = 32'h0000005B.
REQ-010 States SHALL be IDLE, LOAD, PUSH, GAP, READ, CAPTURE, HOLD.
REQ-011 coef_ready SHALL be 1 only in IDLE.
REQ-012 in_ready SHALL be 1 only in IDLE with loaded=1 and coef_valid=0; a coefficient always wins over a simultaneous sample.
REQ-013 A coefficient handshake in cycle T SHALL issue in T+1: scie_valid=1, insn LOAD, rs1 = coefficient, rs2 = tap index zero-extended; the state then returns to IDLE in T+2.
REQ-014 The tap index SHALL increment per LOAD and wrap from NTAPS-1 to 0; that wrap SHALL set loaded=1, and loaded SHALL never clear except by reset.
REQ-015 A sample handshake in cycle T SHALL issue in T+1 (PUSH): scie_valid=1, insn PUSH, rs1 = sample, rs2 = 0.
REQ-016 GAP SHALL occupy T+2 with scie_valid=0.
REQ-017 READ SHALL occupy T+3 with scie_valid=1, insn READ, rs1 = 0, rs2 = 0.
REQ-018 In CAPTURE (T+4), scie_rd_real and scie_rd_imag SHALL be registered into out_real and out_imag at the end of the cycle.
REQ-019 In HOLD, from T+5, out_valid SHALL be 1 and out_real and out_imag SHALL be stable until out_ready=1; the state SHALL be IDLE the cycle after that handshake.
REQ-020 Outside LOAD, PUSH and READ, scie_valid SHALL be 0, and scie_insn, scie_rs1_* and scie_rs2 SHALL hold their last issued values.
REQ-021 Minimum sample-to-sample spacing SHALL be 6 cycles, and only one operation SHALL be in flight.
REQ-022 Arithmetic SHALL be pass-through only; no width change or saturation SHALL occur on data.

Reset
REQ-023 Reset SHALL force, on the next edge: state IDLE, index 0, loaded 0.
REQ-024 Reset SHALL force all outputs to 0, except coef_ready, which is 1 in IDLE after reset.
REQ-025 Reset asserted mid-operation (any state) SHALL abandon the operation: no further SCIE issue, no out_valid for it.
REQ-026 Reset SHALL take priority over every handshake in the same cycle.

Configuration
REQ-027 With SCIE_ISSUER_PERF_EN defined, the block SHALL add output result_count (16 bits), reset to 0, incremented on each out handshake and saturating at 16'hFFFF.
REQ-028 Without SCIE_ISSUER_PERF_EN, result_count and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Load: push coefs (3,-21),(-10,-13),(-12,20),(-28,33),(-4,2) with NTAPS=5 -> five LOAD issues with rs2 0..4, rs1 equal to each coef, scie_valid 0 between them; loaded=1 (in_ready rises) after the fifth.
REQ-030 Sample: (-27,-25) accepted at T -> PUSH at T+1 with rs1=(-27,-25), scie_valid 0 at T+2, READ at T+3; bench drives rd=(-606,492) at T+4 -> out_valid=1 with (-606,492) at T+5.
REQ-031 Backpressure: hold out_ready=0 for 3 cycles after out_valid rises -> out_valid and data stable, in_ready=0, no scie_valid; out_ready=1 -> IDLE next cycle.
REQ-032 Ordering: sample offered before load completes -> in_ready=0; coef_valid and in_valid both 1 in IDLE -> LOAD issued, sample waits.
REQ-033 Reset mid-op: assert reset during GAP -> next cycle scie_valid=0, out_valid=0, loaded=0, and no READ issued.
REQ-034 With SCIE_ISSUER_PERF_EN: 3 completed results -> result_count=3; counter preloaded to 16'hFFFF plus one more result -> remains 16'hFFFF.
